// File: rtl/game_pkg.sv
// Shared types and constants for the game controller: state codes, widths,
// and the Moore decode of the control outputs.
package game_pkg;

  localparam int STATE_W = 6;
  localparam int LIVES_W = 4;

  typedef enum logic [STATE_W-1:0] {
    PRE_GAME       = 6'd0,
    PRE_GAME_WAIT  = 6'd1,
    DRAW           = 6'd2,
    DRAW_WAIT      = 6'd3,
    GAME           = 6'd4,
    GAME_WAIT      = 6'd5,
    GAME_OVER      = 6'd6,
    GAME_OVER_WAIT = 6'd7,
    RESPAWN        = 6'd8,
    PAUSED         = 6'd9
  } state_e;

  typedef struct packed {
    logic reset_co;
    logic move_ball;
    logic rd_ld;
    logic reset_movement;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = 4'b0000;
    case (s)
      PRE_GAME, PRE_GAME_WAIT, GAME_OVER, GAME_OVER_WAIT: c = 4'b0000;
      DRAW, DRAW_WAIT, RESPAWN:                           c = 4'b1010;
      GAME, GAME_WAIT:                                    c = 4'b1111;
      PAUSED:                                             c = 4'b1011;
      default:                                            c = 4'b0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/game_fsm_debounce.sv
// Key debouncer: accepted level follows the raw key only after it has
// differed for DEBOUNCE consecutive cycles; rise marks the 0->1 acceptance.
module key_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic level,
  output logic rise
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE - 1);

  logic [7:0] cnt_r;
  logic       level_r;
  logic       rise_r;

  // Stability counter, accepted level and one-cycle rise flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= 8'd0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
    end else if (key != level_r) begin
      if (cnt_r == LAST) begin
        cnt_r   <= 8'd0;
        level_r <= key;
        rise_r  <= key;
      end else begin
        cnt_r   <= cnt_r + 8'd1;
        rise_r  <= 1'b0;
      end
    end else begin
      cnt_r  <= 8'd0;
      rise_r <= 1'b0;
    end
  end

  assign level = level_r;
  assign rise  = rise_r;

endmodule

// File: rtl/game_fsm.sv
// Game phase controller with debounced keys, lives and respawn timing.
// Define GAME_FSM_PAUSE_EN to enable the pause key and the PAUSED state.
module game_fsm
  import game_pkg::*;
#(
  parameter int LIVES          = 3,
  parameter int DEBOUNCE       = 4,
  parameter int RESPAWN_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               pause_key,
  input  logic               miss,
  output logic               reset_co,
  output logic               move_ball,
  output logic               rd_ld,
  output logic               reset_movement,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic [STATE_W-1:0] state
);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [15:0]        RESP_LAST  = 16'(RESPAWN_CYCLES - 1);

  state_e             state_r, state_nxt_s;
  logic [LIVES_W-1:0] lives_r, lives_nxt_s;
  logic [15:0]        resp_cnt_r, resp_cnt_nxt_s;
  ctrl_t              ctrl_r;
  logic               game_over_r;
  logic               go_level_s, go_rise_s, pause_rise_s;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_go_db (
    .clk   (clk),
    .reset (reset),
    .key   (go),
    .level (go_level_s),
    .rise  (go_rise_s)
  );

`ifdef GAME_FSM_PAUSE_EN
  logic pause_level_unused_s;
  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_pause_db (
    .clk   (clk),
    .reset (reset),
    .key   (pause_key),
    .level (pause_level_unused_s),
    .rise  (pause_rise_s)
  );
`else
  logic pause_unused_s;
  assign pause_unused_s = pause_key;
  assign pause_rise_s   = 1'b0;
`endif

  // Next state, lives and respawn count; miss outranks key presses in GAME
  always_comb begin
    state_nxt_s    = state_r;
    lives_nxt_s    = lives_r;
    resp_cnt_nxt_s = 16'd0;
    case (state_r)
      PRE_GAME:       if (go_rise_s) state_nxt_s = PRE_GAME_WAIT; else state_nxt_s = PRE_GAME;
      PRE_GAME_WAIT:  if (!go_level_s) state_nxt_s = DRAW; else state_nxt_s = PRE_GAME_WAIT;
      DRAW: begin
        if (go_rise_s) begin
          state_nxt_s = DRAW_WAIT;
          lives_nxt_s = LIVES_INIT;
        end else begin
          state_nxt_s = DRAW;
        end
      end
      DRAW_WAIT:      if (!go_level_s) state_nxt_s = GAME; else state_nxt_s = DRAW_WAIT;
      GAME: begin
        if (miss) begin
          if (lives_r > 4'd1) begin
            lives_nxt_s = lives_r - 4'd1;
            state_nxt_s = RESPAWN;
          end else begin
            lives_nxt_s = 4'd0;
            state_nxt_s = GAME_OVER;
          end
        end else if (go_rise_s) begin
          state_nxt_s = GAME_WAIT;
        end else if (pause_rise_s) begin
          state_nxt_s = PAUSED;
        end else begin
          state_nxt_s = GAME;
        end
      end
      GAME_WAIT:      if (!go_level_s) state_nxt_s = GAME_OVER; else state_nxt_s = GAME_WAIT;
      GAME_OVER:      if (go_rise_s) state_nxt_s = GAME_OVER_WAIT; else state_nxt_s = GAME_OVER;
      GAME_OVER_WAIT: if (!go_level_s) state_nxt_s = PRE_GAME; else state_nxt_s = GAME_OVER_WAIT;
      RESPAWN: begin
        if (resp_cnt_r == RESP_LAST) begin
          state_nxt_s = GAME;
        end else begin
          state_nxt_s    = RESPAWN;
          resp_cnt_nxt_s = resp_cnt_r + 16'd1;
        end
      end
      PAUSED:         if (pause_rise_s) state_nxt_s = GAME; else state_nxt_s = PAUSED;
      default:        state_nxt_s = PRE_GAME;
    endcase
  end

  // State, lives, counter and outputs registered together from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= PRE_GAME;
      lives_r     <= 4'd0;
      resp_cnt_r  <= 16'd0;
      ctrl_r      <= 4'b0000;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      lives_r     <= lives_nxt_s;
      resp_cnt_r  <= resp_cnt_nxt_s;
      ctrl_r      <= decode_ctrl(state_nxt_s);
      game_over_r <= (state_nxt_s == GAME_OVER) || (state_nxt_s == GAME_OVER_WAIT);
    end
  end

  assign reset_co       = ctrl_r.reset_co;
  assign move_ball      = ctrl_r.move_ball;
  assign rd_ld          = ctrl_r.rd_ld;
  assign reset_movement = ctrl_r.reset_movement;
  assign lives          = lives_r;
  assign game_over      = game_over_r;
  assign state          = state_r;

endmodule

// File: tb/tb_game_fsm.sv
// Self-checking bench for game_fsm: directed scenarios plus randomized key/miss
// traffic, all compared every cycle against a phase-level reference model.
module tb_game_fsm;

  localparam int LIVES = 3;
  localparam int DEB   = 4;
  localparam int RC    = 8;
`ifdef GAME_FSM_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1, go = 1'b0, pause_key = 1'b0, miss = 1'b0;
  logic       reset_co, move_ball, rd_ld, reset_movement, game_over;
  logic [3:0] lives;
  logic [5:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0..3 (pre, draw, game, over), wait flag, respawn
  // cycles remaining, pause flag, lives, and per-key debounce tracking.
  int m_ph, m_wt, m_resp, m_pz, m_lv;
  int g_lev, g_cnt, g_rise, p_lev, p_cnt, p_rise;

  game_fsm #(.LIVES(LIVES), .DEBOUNCE(DEB), .RESPAWN_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .go(go), .pause_key(pause_key), .miss(miss),
    .reset_co(reset_co), .move_ball(move_ball), .rd_ld(rd_ld),
    .reset_movement(reset_movement), .lives(lives), .game_over(game_over),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_wt = 0; m_resp = 0; m_pz = 0; m_lv = 0;
    g_lev = 0; g_cnt = 0; g_rise = 0; p_lev = 0; p_cnt = 0; p_rise = 0;
  endtask

  task automatic deb(input logic raw, inout int lev, inout int cnt, inout int rise);
    rise = 0;
    if (int'(raw) != lev) begin
      cnt++;
      if (cnt == DEB) begin
        lev = int'(raw); rise = int'(raw); cnt = 0;
      end
    end else begin
      cnt = 0;
    end
  endtask

  task automatic model_fsm(input logic m);
    int prise;
    prise = PAUSE_EN ? p_rise : 0;
    if (m_resp > 0) begin
      m_resp--;
    end else if (m_pz) begin
      if (prise != 0) m_pz = 0;
    end else if (m_wt) begin
      if (g_lev == 0) begin m_wt = 0; m_ph = (m_ph + 1) % 4; end
    end else if (m_ph == 2) begin
      if (m) begin
        if (m_lv > 1) begin m_lv--; m_resp = RC; end
        else begin m_lv = 0; m_ph = 3; end
      end else if (g_rise != 0) m_wt = 1;
      else if (prise != 0) m_pz = 1;
    end else if (g_rise != 0) begin
      m_wt = 1;
      if (m_ph == 1) m_lv = LIVES;
    end
  endtask

  function automatic int exp_code();
    if (m_resp > 0) return 8;
    if (m_pz != 0) return 9;
    return m_ph * 2 + m_wt;
  endfunction

  task automatic step(input logic g, input logic p, input logic m, input logic r);
    go = g; pause_key = p; miss = m; reset = r;
    @(posedge clk);
    if (r) model_reset();
    else begin
      model_fsm(m);
      deb(g, g_lev, g_cnt, g_rise);
      deb(p, p_lev, p_cnt, p_rise);
    end
    #1;
    chk("state", 16'(state), 16'(exp_code()));
    chk("lives", 16'(lives), 16'(m_lv));
    chk("game_over", 16'(game_over), 16'(m_ph == 3));
    chk("reset_co", 16'(reset_co), 16'(m_ph == 1 || m_ph == 2));
    chk("rd_ld", 16'(rd_ld), 16'(m_ph == 1 || m_ph == 2));
    chk("move_ball", 16'(move_ball), 16'(m_ph == 2 && m_resp == 0 && m_pz == 0));
    chk("reset_movement", 16'(reset_movement), 16'(m_ph == 2 && m_resp == 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_go();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
  endtask

  task automatic press_pause();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
  endtask

  initial begin
    int gh, ph;
    logic g, p;
    model_reset();

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_lives", 16'(lives), 16'd0);
    idle(2);

    // Short press is filtered, full press and release step PRE_GAME -> DRAW
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    chk("short_press", 16'(state), 16'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_wait", 16'(state), 16'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_wait_hold", 16'(state), 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("draw", 16'(state), 16'd2);
    press_go();
    chk("game", 16'(state), 16'd4);
    chk("game_lives", 16'(lives), 16'd3);

    // Three misses: two respawns, then game over
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("miss1_state", 16'(state), 16'd8);
    chk("miss1_lives", 16'(lives), 16'd2);
    chk("respawn_move", 16'(move_ball), 16'd0);
    idle(19);
    chk("respawn_done", 16'(state), 16'd4);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("miss2_lives", 16'(lives), 16'd1);
    idle(19);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("miss3_state", 16'(state), 16'd6);
    chk("miss3_lives", 16'(lives), 16'd0);
    chk("miss3_over", 16'(game_over), 16'd1);
    press_go();
    chk("loop_back", 16'(state), 16'd0);
    press_go();
    press_go();
    chk("game2", 16'(state), 16'd4);

    // Miss coincident with a go rise pulse
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("miss_go_state", 16'(state), 16'd8);
    chk("miss_go_lives", 16'(lives), 16'd2);
    idle(12);
    chk("miss_go_after", 16'(state), 16'd4);

    // Reset in the third respawn cycle
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    chk("mid_respawn", 16'(state), 16'd8);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_resp_state", 16'(state), 16'd0);
    chk("rst_resp_lives", 16'(lives), 16'd0);
    chk("rst_resp_co", 16'(reset_co), 16'd0);
    idle(2);

    // Pause behaviour depends on the build
    press_go();
    press_go();
    press_pause();
    if (PAUSE_EN) begin
      chk("paused", 16'(state), 16'd9);
      chk("paused_move", 16'(move_ball), 16'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      press_go();
      chk("paused_ignore", 16'(state), 16'd9);
      chk("paused_lives", 16'(lives), 16'd3);
      press_pause();
      chk("unpaused", 16'(state), 16'd4);
    end else begin
      chk("no_pause", 16'(state), 16'd4);
    end

    // Randomized traffic
    gh = 0; ph = 0; g = 1'b0; p = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (gh == 0) begin g = 1'($urandom_range(0, 1)); gh = $urandom_range(1, 9); end
      if (ph == 0) begin p = 1'($urandom_range(0, 1)); ph = $urandom_range(1, 12); end
      gh--; ph--;
      step(g, p, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 499) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_fsm.md
GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 Parameter LIVES, default 3: lives loaded at game start; legal range 1..15.
REQ-002 Parameter DEBOUNCE, default 4: consecutive stable cycles before a key level is accepted; legal range 1..255.
REQ-003 Parameter RESPAWN_CYCLES, default 8: cycles spent in RESPAWN after a life is lost; legal range 1..65535.
REQ-004 The module SHALL have a single clock; reset is synchronous and active-high.
REQ-005 Port clk, in, 1: the single clock; all state changes on its rising edge.
REQ-006 Port reset, in, 1: synchronous, active-high reset.
REQ-007 Port go, in, 1: raw advance key, high = pressed.
REQ-008 Port pause_key, in, 1: raw pause key, high = pressed.
REQ-009 Port miss, in, 1: single-cycle datapath pulse, ball missed.
REQ-010 Port reset_co, out, 1: score counter enable (0 clears the score).
REQ-011 Port move_ball, out, 1: ball motion enable.
REQ-012 Port rd_ld, out, 1: paddle draw enable.
REQ-013 Port reset_movement, out, 1: movement enable (0 holds movement in reset).
REQ-014 Port lives, out, 4: lives remaining.
REQ-015 Port game_over, out, 1: high while in GAME_OVER or GAME_OVER_WAIT.
REQ-016 Port state, out, 6: current state code, zero-extended.

Function
REQ-017 States and codes: PRE_GAME=0, PRE_GAME_WAIT=1, DRAW=2, DRAW_WAIT=3, GAME=4, GAME_WAIT=5, GAME_OVER=6, GAME_OVER_WAIT=7, RESPAWN=8, PAUSED=9; any other code -> PRE_GAME next cycle.
REQ-018 go and pause_key SHALL each be debounced: the accepted level changes only after the raw input has differed from it for DEBOUNCE consecutive cycles; a rise pulse is one cycle long and occurs on the cycle the accepted level goes 0->1.
REQ-019 Press/release stepping: X -> X_WAIT on a go rise pulse; X_WAIT -> next phase on the cycle the accepted go level is 0.
REQ-020 Phase order: PRE_GAME, DRAW, GAME, GAME_OVER, then back to PRE_GAME.
REQ-021 Entering DRAW_WAIT SHALL load lives with LIVES.
REQ-022 In GAME, a miss pulse with lives>1 SHALL decrement lives and enter RESPAWN.
REQ-023 In GAME, a miss pulse with lives==1 SHALL set lives to 0 and enter GAME_OVER directly.
REQ-024 In GAME, miss has priority over a go or pause rise pulse in the same cycle.
REQ-025 RESPAWN SHALL last exactly RESPAWN_CYCLES cycles, then return to GAME; go, pause_key and miss are ignored in RESPAWN.
REQ-026 miss is ignored in every state other than GAME.
REQ-027 Outputs are Moore (decoded from the current state only) in the order reset_co, move_ball, rd_ld, reset_movement:
- PRE_GAME*, GAME_OVER*: 0,0,0,0
- DRAW*: 1,0,1,0
- GAME, GAME_WAIT: 1,1,1,1
- RESPAWN: 1,0,1,0
- PAUSED: 1,0,1,1
REQ-028 lives SHALL hold its value in all states except on load (REQ-021) or decrement (REQ-022, REQ-023); it never wraps below 0.

Reset
REQ-029 On reset, the next state SHALL be PRE_GAME, lives 0, debouncer accepted levels 0, debouncer counters 0, respawn counter 0.
REQ-030 Reset SHALL override every event in any state, including mid-RESPAWN and mid-debounce.
REQ-031 All outputs SHALL read their PRE_GAME values on the first cycle after reset.

Configuration
REQ-032 Macro GAME_FSM_PAUSE_EN defined: in GAME, a pause rise pulse enters PAUSED; in PAUSED, a pause rise pulse returns to GAME.
REQ-033 In PAUSED, go is ignored.
REQ-034 Macro GAME_FSM_PAUSE_EN undefined: pause_key stays a port but is ignored, PAUSED is unreachable, and the pause debouncer is not instantiated.

Structure
REQ-035 Shared package game_pkg SHALL hold the state enum and codes, the 6-bit state width constant, and the 4-bit lives width constant.
REQ-036 One sub-module key_debounce (parameter DEBOUNCE; outputs level and rise) SHALL be instantiated per key.

Verification (DEBOUNCE=4, LIVES=3, RESPAWN_CYCLES=8)
REQ-037 go high for 3 cycles then low -> no state change; go high 4 cycles -> state 1 on cycle 5 after rise; release -> state 2 after 4 low cycles.
REQ-038 Full loop with presses -> states 0,1,2,3,4,5,6,7,0; lives==3 in state 4; game_over==1 only in states 6 and 7.
REQ-039 In GAME, 3 miss pulses spaced 20 cycles apart -> lives 2 then 1 with 8-cycle RESPAWN each (move_ball=0, reset_movement=0); third miss -> state 6, lives 0.
REQ-040 miss and go rise in the same GAME cycle -> state 8, lives decremented, no entry to state 5.
REQ-041 Reset asserted in cycle 3 of RESPAWN -> state 0, lives 0, all outputs 0 the next cycle.
REQ-042 GAME_FSM_PAUSE_EN defined: pause press in GAME -> state 9 with move_ball=0; miss ignored; second press -> state 4. Undefined: pause press leaves the state at 4.
